proc_out_writer: RTL
====================

Name: proc_out_writer

Overview:
- Downstream stage of the brightness/threshold processor.
- Captures processed pixel words (processor data_out / data_out_vld / done) into a small FIFO and writes them to image memory through a valid/ready write port at consecutive word addresses.
- The processor has no backpressure, so the block absorbs memory stalls, flags overflow, and signals completion once the last word is committed to memory.

Parameters:
- DATA_WIDTH, 32, processed word width (32 or 64); multiple of `COLOR_SIZE.
- ADDR_WIDTH, 16, memory word-address width.
- FIFO_DEPTH, 8, buffer entries; power of 2, >= 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a frame (honoured in IDLE only).
- base_addr  in  ADDR_WIDTH  first write address; sampled on accepted start.
- in_vld  in  1  processed word valid (processor data_out_vld).
- in_data  in  DATA_WIDTH  processed word (processor data_out).
- in_last  in  1  final word marker (processor done); meaningful only with in_vld.
- mem_wr_vld  out  1  write request valid.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_data  out  DATA_WIDTH  write data.
- mem_ready  in  1  memory accepts the write when mem_wr_vld && mem_ready.
- busy  out  1  high in RUN and DRAIN.
- wr_done  out  1  one-cycle pulse when the frame is fully written.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- word_cnt  out  ADDR_WIDTH+1  words written in the current/last frame.

Behaviour:
- Reset (async, any state): FSM=IDLE, FIFO empty, pointers 0.
  - mem_wr_vld=0, mem_addr=0, mem_data=0, busy=0, wr_done=0, overflow=0, word_cnt=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: in_vld ignored, nothing stored. On start: load address counter with base_addr, clear word_cnt and overflow, go to RUN.
  - RUN: each in_vld cycle pushes in_data. If the pushed word has in_last=1, go to DRAIN.
  - DRAIN: in_vld ignored. When the FIFO is empty and no write is pending (mem_wr_vld=0, or final handshake this cycle), go to DONE.
  - DONE: wr_done=1 for exactly one cycle, then IDLE.
  - start outside IDLE is ignored.
- FIFO push rules:
  - Push accepted if not full, or if full and a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow set (sticky until next accepted start or reset).
  - A dropped word with in_last=1 still moves the FSM to DRAIN.
- Write port:
  - mem_wr_vld is registered; asserts the cycle after the head entry becomes available.
  - Minimum latency: in_vld at cycle N gives mem_wr_vld at N+1.
  - While mem_wr_vld=1 && mem_ready=0, mem_addr and mem_data hold stable.
  - On handshake: address += 1 (mod 2^ADDR_WIDTH, silent wrap), word_cnt += 1, next entry presented the following cycle if present (back-to-back writes at 1 word/cycle with mem_ready=1).
- FIFO occupancy counts the output register as one entry, so total buffering = FIFO_DEPTH.
- Pointers wrap mod FIFO_DEPTH.
- Full/empty derived from an occupancy counter of width log2(FIFO_DEPTH)+1.
- word_cnt saturates at 2^(ADDR_WIDTH+1)-1.
- Reset mid-frame discards all buffered words; no partial-state recovery.

Optional Feature:
- Macro: PROC_OUT_CHECKSUM_EN.
- Defined:
  - Adds output checksum [15:0], reset/start value 0.
  - On each memory handshake, adds every `COLOR_SIZE-wide channel of mem_data (zero-extended), mod 2^16.
  - Value is final and stable when wr_done pulses; holds until next start.
- Not defined: no checksum port or logic; all other behaviour identical.

Test Plan:
- Basic frame, DATA_WIDTH=32:
  - Stimulus: base_addr=0x0100; 4 consecutive words 0x01020304, 0x05060708, 0x090A0B0C, 0xFFFFFFFF (last with in_last), mem_ready=1.
  - Response: writes to 0x0100..0x0103 in order, first mem_wr_vld 1 cycle after first in_vld; wr_done pulse; word_cnt=4; overflow=0.
- Stall hold:
  - Stimulus: mem_ready=0 for 5 cycles with 3 words pushed.
  - Response: mem_addr/mem_data constant during stall; after release, 3 back-to-back writes; no data loss.
- Overflow, FIFO_DEPTH=8:
  - Stimulus: mem_ready=0; push 10 words, last with in_last.
  - Response: words 9–10 dropped; overflow=1; after mem_ready=1, exactly 8 writes then wr_done; word_cnt=8.
- Full with simultaneous pop:
  - Stimulus: FIFO full, handshake and in_vld in the same cycle.
  - Response: word accepted; overflow stays 0.
- Address wrap and ignored inputs:
  - Stimulus: ADDR_WIDTH=16, base_addr=0xFFFE, 3 words; also in_vld pulses in IDLE, and start asserted in RUN.
  - Response: addresses 0xFFFE, 0xFFFF, 0x0000; IDLE words not written; start in RUN has no effect.
- Reset mid-frame and checksum:
  - Stimulus: rst_n low during DRAIN with 2 words buffered.
  - Response: outputs return to reset values immediately; no wr_done.
  - Checksum (PROC_OUT_CHECKSUM_EN defined): words 0x01020304 and 0xFFFFFFFF give 0x000A + 0x03FC = 0x0406.

Source files
------------

// File: rtl/proc_out_writer.sv
// proc_out_writer: buffers processed pixel words from the brightness/threshold
// processor and streams them to image memory at consecutive word addresses.
// The output register is the last FIFO slot, so total buffering is FIFO_DEPTH.
// Optional feature: define PROC_OUT_CHECKSUM_EN to add a 16-bit channel-sum
// checksum output over every word committed to memory.

`ifndef COLOR_SIZE
`define COLOR_SIZE 8
`endif

module proc_out_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  mem_wr_vld,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  wr_done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   word_cnt
`ifdef PROC_OUT_CHECKSUM_EN
    ,
    output logic [15:0]           checksum
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] buf_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      occ;

    logic pop;
    logic push_req;
    logic push_ok;
    logic full;
    logic out_free;
    logic arr_empty;
    logic load_head;
    logic load_bypass;
    logic arr_wr;
    logic start_ok;
    logic drain_empty;

    // Saturating increment for the frame word counter.
    function automatic logic [ADDR_WIDTH:0] sat_inc(input logic [ADDR_WIDTH:0] c);
        if (&c) begin
            return c;
        end
        return c + (ADDR_WIDTH+1)'(1);
    endfunction

`ifdef PROC_OUT_CHECKSUM_EN
    // Sum of all colour channels of one word, zero-extended, mod 2^16.
    function automatic logic [15:0] chan_sum(input logic [DATA_WIDTH-1:0] w);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < DATA_WIDTH / `COLOR_SIZE; i++) begin
            s = s + 16'(w[i*`COLOR_SIZE +: `COLOR_SIZE]);
        end
        return s;
    endfunction
`endif

    // A word in the output register is always the oldest entry; the array
    // holds the remaining occ - mem_wr_vld entries behind it.
    assign pop         = mem_wr_vld & mem_ready;
    assign push_req    = (state == RUN) & in_vld;
    assign full        = (occ == OCC_FULL);
    assign push_ok     = push_req & (~full | pop);
    assign out_free    = ~mem_wr_vld | pop;
    assign arr_empty   = (occ == OCC_W'(mem_wr_vld));
    assign load_head   = out_free & ~arr_empty;
    assign load_bypass = out_free & arr_empty & push_ok;
    assign arr_wr      = push_ok & ~load_bypass;
    assign start_ok    = start & (state == IDLE);
    assign drain_empty = (occ == OCC_W'(pop));

    assign busy    = (state == RUN) | (state == DRAIN);
    assign wr_done = (state == DONE);

    // Frame sequencing: next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (in_vld && in_last) state_nxt = DRAIN;
            DRAIN:   if (drain_empty) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame sequencing: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Buffer storage; contents are don't-care whenever occupancy says empty.
    always_ff @(posedge clk) begin
        if (arr_wr) begin
            buf_mem[wr_ptr] <= in_data;
        end
    end

    // Buffer pointers and total occupancy (including the output register).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (arr_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (load_head) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ <= occ + OCC_W'(push_ok) - OCC_W'(pop);
        end
    end

    // Output register: refilled from the buffer head, or straight from the
    // input when the buffer is empty so a word reaches memory one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr_vld <= 1'b0;
            mem_data   <= '0;
        end else if (out_free) begin
            mem_wr_vld <= load_head | load_bypass;
            if (load_head) begin
                mem_data <= buf_mem[rd_ptr];
            end else if (load_bypass) begin
                mem_data <= in_data;
            end
        end
    end

    // Write address: loaded at frame start, advanced on each handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr <= '0;
        end else if (start_ok) begin
            mem_addr <= base_addr;
        end else if (pop) begin
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
        end
    end

    // Frame statistics: committed-word count and sticky drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            overflow <= 1'b0;
        end else if (start_ok) begin
            word_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                word_cnt <= sat_inc(word_cnt);
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef PROC_OUT_CHECKSUM_EN
    // Running channel-sum over every committed word of the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum + chan_sum(mem_data);
        end
    end
`endif

endmodule
